clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-set controller for the 50 MHz wall clock. It synchronises and debounces the raw active-low push-buttons and runs a RUN / SET_HR / SET_MIN mode FSM. It emits single-cycle `set_hr`, `set_min` and `AM2PM` increment pulses to the CLOCK counter block, with auto-repeat on held keys. It also drives blanking strobes so the BCD/HEX stage can blink the field being edited.

## Interface
Parameters:
- `DEBOUNCE_CYC`, 1_000_000: cycles a synchronised key level must be stable to be accepted (20 ms).
- `HOLD_CYC`, 25_000_000: cycles a key is held before auto-repeat starts (0.5 s).
- `REPEAT_CYC`, 5_000_000: auto-repeat period (100 ms).
- `BLINK_CYC`, 12_500_000: blink half-period (250 ms).
- `TIMEOUT_CYC`, 500_000_000: cycles with no accepted press before a SET state returns to RUN (10 s).

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `rst` in 1: asynchronous, active-low reset.
- `key_mode_n` in 1: raw mode button, active-low, asynchronous.
- `key_up_n` in 1: raw increment button, active-low, asynchronous.
- `key_ampm_n` in 1: raw AM/PM button, active-low, asynchronous.
- `set_hr` out 1: one-cycle hour-increment pulse.
- `set_min` out 1: one-cycle minute-increment pulse.
- `AM2PM` out 1: one-cycle AM/PM toggle pulse.
- `mode` out 2: 0 = RUN, 1 = SET_HR, 2 = SET_MIN; 3 is never driven.
- `blank_hr` out 1: high means the hour digits are blanked.
- `blank_min` out 1: high means the minute digits are blanked.

## Operation
- **Input conditioning.** Each key passes through a 2-FF synchroniser, both flops reset to 1.
- **Debounce.**
  - A per-key counter counts consecutive cycles in which the synchronised level differs from the debounced level. It clears on any match.
  - When the counter reaches `DEBOUNCE_CYC`, the debounced level flips and the counter clears.
  - A *press event* is a debounced 1→0 flip. Releases generate no event.
- **FSM transitions.**
  - RUN → SET_HR on a mode press.
  - SET_HR → SET_MIN on a mode press.
  - SET_MIN → RUN on a mode press.
  - Any SET state → RUN when the inactivity counter reaches `TIMEOUT_CYC`.
- **Inactivity counter.**
  - Runs only in SET states.
  - Clears on any press event, on any auto-repeat pulse, and on state entry.
- **Up key.**
  - In SET_HR, an up press pulses `set_hr`; in SET_MIN it pulses `set_min`. In RUN the up key is ignored, with no pulse and no repeat.
  - **Auto-repeat.** While debounced up stays pressed in a SET state, a hold counter runs from the press event. The first repeat pulse comes `HOLD_CYC` cycles after the press, then one every `REPEAT_CYC` cycles until debounced release.
- **AM/PM key.**
  - Each press pulses `AM2PM` once in every state.
  - No auto-repeat.
- **Simultaneous events.**
  - Mode press and up press in the same cycle: the mode transition is taken and the up press is discarded.
  - AM/PM is independent and may pulse in the same cycle as `set_hr` or `set_min`.
- **Mode change while up is held.**
  - Repeat stops immediately.
  - No further increments occur until up is released and pressed again.
- **Blink.**
  - A phase bit toggles every `BLINK_CYC` cycles.
  - The phase clears, and its counter zeroes, on SET-state entry and on every `set_hr`/`set_min` pulse, so edited digits stay visible while adjusting.
  - `blank_hr` = SET_HR && phase; `blank_min` = SET_MIN && phase.
- **Arithmetic.**
  - Every counter is `$clog2(max+1)` bits wide, saturates at its terminal value, and never wraps.
  - Terminal compares use `==`.
- **Reset.**
  - All outputs are 0 and `mode` = RUN.
  - Synchronisers and debounced levels are 1 (released); all counters are 0.
  - Reset asserted mid-hold or mid-SET returns to RUN at once and drops any in-progress pulse.
  - After reset release, keys already held low produce a press event after the debounce delay. This is intended.

## Timing
- All outputs are registered.
- Each pulse is exactly 1 cycle wide; two pulses from the same output are never adjacent.
- **Latency:** a raw key edge at cycle t produces its pulse, or its `mode` change, at cycle t+3+`DEBOUNCE_CYC` (2 synchroniser + debounce + output register).
- `mode` updates in the same cycle as the transition pulse would have; the first `blank_*` value of a new state appears with the new `mode`.
- **Repeat spacing:** press pulse at p, repeats at p+`HOLD_CYC`, p+`HOLD_CYC`+`REPEAT_CYC`, and so on.
- Bounce shorter than `DEBOUNCE_CYC` generates no event.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=4, `HOLD_CYC`=20, `REPEAT_CYC`=5, `BLINK_CYC`=8, `TIMEOUT_CYC`=100.
- **Bounce filtering.** Mode key bounces (low 2, high 1, low 3 cycles), then held low from cycle t → exactly one mode change RUN→SET_HR, at t+7; no extra transitions.
- **Mode cycling.** Three clean mode presses → `mode` 0→1→2→0; `blank_hr` is high only in mode 1 with phase set, `blank_min` only in mode 2.
- **Auto-repeat.** In SET_HR, hold up for 50 cycles past its first pulse at p → `set_hr` pulses at p, p+20, p+25, p+30, …, p+45 (7 total); `set_min` stays 0.
- **Timeout.** Enter SET_MIN, no further keys → `mode` returns to 0 exactly 100 cycles after entry; pressing up in RUN afterwards yields no pulse.
- **Simultaneous press.** Mode and up pressed on the same cycle in SET_HR → `mode`=2, no `set_hr` or `set_min` pulse; an `AM2PM` press alongside still pulses once.
- **Reset mid-repeat.** `rst` pulled low while up is repeating in SET_MIN → all outputs 0 and `mode`=0 asynchronously; after release with up still held, no increment occurs (RUN ignores up).

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set controller for the wall clock.
// Synchronises and debounces three raw active-low keys and runs a RUN / SET_HR / SET_MIN
// mode FSM. Emits one-cycle increment pulses with auto-repeat on a held up key, and
// blanking strobes so the display stage can blink the field being edited.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   key_mode_n - raw mode key (active-low, asynchronous)
//   key_up_n   - raw increment key (active-low, asynchronous)
//   key_ampm_n - raw AM/PM key (active-low, asynchronous)
//   set_hr     - one-cycle hour increment pulse
//   set_min    - one-cycle minute increment pulse
//   AM2PM      - one-cycle AM/PM toggle pulse
//   mode       - 0 RUN, 1 SET_HR, 2 SET_MIN
//   blank_hr   - hour digits blanked
//   blank_min  - minute digits blanked
module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned HOLD_CYC     = 25_000_000,
  parameter int unsigned REPEAT_CYC   = 5_000_000,
  parameter int unsigned BLINK_CYC    = 12_500_000,
  parameter int unsigned TIMEOUT_CYC  = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_up_n,
  input  logic       key_ampm_n,
  output logic       set_hr,
  output logic       set_min,
  output logic       AM2PM,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RepMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam int unsigned BlkW   = $clog2(BLINK_CYC + 1);
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DbW-1:0]  DbMax   = DbW'(DEBOUNCE_CYC);
  localparam logic [RepW-1:0] RepSat  = RepW'(RepMax);
  localparam logic [RepW-1:0] HoldEnd = RepW'(HOLD_CYC - 1);
  localparam logic [RepW-1:0] RepEnd  = RepW'(REPEAT_CYC - 1);
  localparam logic [BlkW-1:0] BlkSat  = BlkW'(BLINK_CYC);
  localparam logic [BlkW-1:0] BlkEnd  = BlkW'(BLINK_CYC - 1);
  localparam logic [TmoW-1:0] TmoSat  = TmoW'(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoEnd  = TmoW'(TIMEOUT_CYC - 1);

  // Key index within the packed key vectors.
  localparam int unsigned KMode = 0;
  localparam int unsigned KUp   = 1;
  localparam int unsigned KAmpm = 2;

  typedef enum logic [1:0] {StRun = 2'd0, StSetHr = 2'd1, StSetMin = 2'd2} state_e;

  logic [2:0]     key_raw, sync1_q, sync2_q, deb_q, deb_d, press;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [RepW-1:0] rep_q, rep_d;
  logic            rep_active_q, rep_active_d, rep_started_q, rep_started_d;
  logic [BlkW-1:0] blk_q, blk_d;
  logic            phase_q, phase_d;
  logic            set_hr_q, set_hr_d, set_min_q, set_min_d, am2pm_q, am2pm_d;
  logic            blank_hr_q, blank_hr_d, blank_min_q, blank_min_d;

  logic in_set, up_down, rep_hit, rep_pending, rep_fire, tmo_fire, up_take, inc, entry;

  assign key_raw = {key_ampm_n, key_up_n, key_mode_n};

  // Debounce: the level flips on the cycle the mismatch counter has already reached its
  // terminal value, which is what gives the sync + debounce + output-register latency.
  always_comb begin
    deb_d = deb_q;
    press = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          deb_d[i] = sync2_q[i];
          press[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_set  = (state_q != StRun);
    up_down = ~deb_q[KUp];
    rep_hit = rep_started_q ? (rep_q == RepEnd) : (rep_q == HoldEnd);
    // Any accepted press or repeat clears inactivity, so it also suppresses the timeout.
    rep_pending = rep_active_q && up_down && rep_hit;
    tmo_fire    = in_set && (tmo_q == TmoEnd) && (press == '0) && !rep_pending;
    rep_fire    = rep_pending && !press[KMode];
    up_take     = press[KUp] && in_set && !press[KMode];
    inc         = up_take || rep_fire;

    state_d = state_q;
    if (press[KMode]) begin
      case (state_q)
        StRun:   state_d = StSetHr;
        StSetHr: state_d = StSetMin;
        default: state_d = StRun;
      endcase
    end else if (tmo_fire) begin
      state_d = StRun;
    end
    entry = (state_d != state_q) && (state_d != StRun);

    // A mode change while up is held kills the repeat until a fresh press.
    rep_d         = rep_q;
    rep_active_d  = rep_active_q;
    rep_started_d = rep_started_q;
    if (up_take) begin
      rep_active_d  = 1'b1;
      rep_started_d = 1'b0;
      rep_d         = '0;
    end else if (!rep_active_q || !up_down || (state_d != state_q)) begin
      rep_active_d  = 1'b0;
      rep_started_d = 1'b0;
      rep_d         = '0;
    end else if (rep_fire) begin
      rep_started_d = 1'b1;
      rep_d         = '0;
    end else if (rep_q != RepSat) begin
      rep_d = rep_q + 1'b1;
    end

    tmo_d = tmo_q;
    if ((state_d == StRun) || (state_d != state_q) || (press != '0) || rep_fire) begin
      tmo_d = '0;
    end else if (tmo_q != TmoSat) begin
      tmo_d = tmo_q + 1'b1;
    end

    // Restarting the blink on entry and on every increment keeps edited digits visible.
    blk_d   = blk_q;
    phase_d = phase_q;
    if (entry || inc) begin
      blk_d   = '0;
      phase_d = 1'b0;
    end else if (blk_q == BlkEnd) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end else if (blk_q != BlkSat) begin
      blk_d = blk_q + 1'b1;
    end

    set_hr_d    = inc && (state_q == StSetHr);
    set_min_d   = inc && (state_q == StSetMin);
    am2pm_d     = press[KAmpm];
    blank_hr_d  = (state_d == StSetHr) && phase_d;
    blank_min_d = (state_d == StSetMin) && phase_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      deb_q         <= '1;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      state_q       <= StRun;
      tmo_q         <= '0;
      rep_q         <= '0;
      rep_active_q  <= 1'b0;
      rep_started_q <= 1'b0;
      blk_q         <= '0;
      phase_q       <= 1'b0;
      set_hr_q      <= 1'b0;
      set_min_q     <= 1'b0;
      am2pm_q       <= 1'b0;
      blank_hr_q    <= 1'b0;
      blank_min_q   <= 1'b0;
    end else begin
      sync1_q       <= key_raw;
      sync2_q       <= sync1_q;
      deb_q         <= deb_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      rep_q         <= rep_d;
      rep_active_q  <= rep_active_d;
      rep_started_q <= rep_started_d;
      blk_q         <= blk_d;
      phase_q       <= phase_d;
      set_hr_q      <= set_hr_d;
      set_min_q     <= set_min_d;
      am2pm_q       <= am2pm_d;
      blank_hr_q    <= blank_hr_d;
      blank_min_q   <= blank_min_d;
    end
  end

  assign set_hr    = set_hr_q;
  assign set_min   = set_min_q;
  assign AM2PM     = am2pm_q;
  assign mode      = state_q;
  assign blank_hr  = blank_hr_q;
  assign blank_min = blank_min_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short timing parameters.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] keys_n;  // [0] mode, [1] up, [2] ampm
  logic       set_hr, set_min, am2pm, blank_hr, blank_min;
  logic [1:0] mode;

  clock_set_ctrl #(
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (20),
    .REPEAT_CYC  (5),
    .BLINK_CYC   (8),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode_n(keys_n[0]),
    .key_up_n  (keys_n[1]),
    .key_ampm_n(keys_n[2]),
    .set_hr    (set_hr),
    .set_min   (set_min),
    .AM2PM     (am2pm),
    .mode      (mode),
    .blank_hr  (blank_hr),
    .blank_min (blank_min)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Output monitor, sampled on the falling edge.
  int         hr_cnt = 0, min_cnt = 0, ap_cnt = 0;
  int         mode_chg_n = 0, mode_chg_cyc = 0, viol = 0, seen_bh = 0, seen_bm = 0;
  logic [1:0] mode_prev = 2'd0;
  int         hr_times[$];
  bit         blank_hr_log [4096];

  always @(negedge clk) begin
    if (set_hr) begin
      hr_cnt <= hr_cnt + 1;
      hr_times.push_back(cyc);
    end
    if (set_min) min_cnt <= min_cnt + 1;
    if (am2pm) ap_cnt <= ap_cnt + 1;
    if (mode != mode_prev) begin
      mode_chg_n   <= mode_chg_n + 1;
      mode_chg_cyc <= cyc;
    end
    mode_prev <= mode;
    if ((blank_hr && mode != 2'd1) || (blank_min && mode != 2'd2) || mode == 2'd3)
      viol <= viol + 1;
    if (blank_hr) seen_bh <= seen_bh + 1;
    if (blank_min) seen_bm <= seen_bm + 1;
    if (cyc < 4096) blank_hr_log[cyc] <= blank_hr;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    keys_n = 3'b111;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic press(input logic [2:0] mask);
    keys_n = ~mask;
    repeat (8) tick();
    keys_n = 3'b111;
    repeat (14) tick();
  endtask

  typedef struct {
    logic [2:0] mask;
    int         exp_mode;
    int         exp_hr;
    int         exp_min;
    int         exp_ap;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int h0, m0, a0, n0, t, e, ret;
    bit found;

    //            mask    mode hr min ap
    vecs[0]  = '{3'b001, 1, 0, 0, 0};
    vecs[1]  = '{3'b010, 1, 1, 0, 0};
    vecs[2]  = '{3'b010, 1, 1, 0, 0};
    vecs[3]  = '{3'b001, 2, 0, 0, 0};
    vecs[4]  = '{3'b010, 2, 0, 1, 0};
    vecs[5]  = '{3'b100, 2, 0, 0, 1};
    vecs[6]  = '{3'b110, 2, 0, 1, 1};
    vecs[7]  = '{3'b001, 0, 0, 0, 0};
    vecs[8]  = '{3'b010, 0, 0, 0, 0};
    vecs[9]  = '{3'b100, 0, 0, 0, 1};
    vecs[10] = '{3'b011, 1, 0, 0, 0};
    vecs[11] = '{3'b111, 2, 0, 0, 1};
    vecs[12] = '{3'b001, 0, 0, 0, 0};

    // Reset state.
    rst    = 1'b0;
    keys_n = 3'b111;
    repeat (3) tick();
    check("reset_mode", int'(mode), 0);
    check("reset_outs", int'({set_hr, set_min, am2pm, blank_hr, blank_min}), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Bounce filtering then a clean hold.
    n0 = mode_chg_n;
    keys_n[0] = 1'b0; repeat (2) tick();
    keys_n[0] = 1'b1; repeat (1) tick();
    keys_n[0] = 1'b0; repeat (3) tick();
    keys_n[0] = 1'b1; repeat (1) tick();
    keys_n[0] = 1'b0;
    t = cyc;
    repeat (12) tick();
    keys_n[0] = 1'b1;
    repeat (14) tick();
    check("bounce_changes", mode_chg_n - n0, 1);
    check("bounce_latency", mode_chg_cyc, t + 7);
    check("bounce_mode", int'(mode), 1);
    check("blink_entry", int'(blank_hr_log[t + 7]), 0);
    check("blink_on", int'(blank_hr_log[t + 15]), 1);
    check("blink_off", int'(blank_hr_log[t + 23]), 0);

    // Table of single presses and simultaneous presses.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      h0 = hr_cnt;
      m0 = min_cnt;
      a0 = ap_cnt;
      press(vecs[i].mask);
      check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].exp_mode);
      check($sformatf("vec%0d_hr", i), hr_cnt - h0, vecs[i].exp_hr);
      check($sformatf("vec%0d_min", i), min_cnt - m0, vecs[i].exp_min);
      check($sformatf("vec%0d_ap", i), ap_cnt - a0, vecs[i].exp_ap);
    end
    check("blank_hr_seen", int'(seen_bh > 0), 1);
    check("blank_min_seen", int'(seen_bm > 0), 1);

    // Auto-repeat in SET_HR.
    do_reset();
    press(3'b001);
    m0 = min_cnt;
    hr_times.delete();
    keys_n[1] = 1'b0;
    t = cyc + 7;
    repeat (47) tick();
    keys_n[1] = 1'b1;
    repeat (30) tick();
    check("repeat_count", hr_times.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < hr_times.size())
        check($sformatf("repeat_t%0d", i), hr_times[i] - t, (i == 0) ? 0 : 15 + 5 * i);
    end
    check("repeat_min", min_cnt - m0, 0);

    // Timeout out of SET_MIN.
    do_reset();
    press(3'b001);
    press(3'b001);
    check("tmo_enter", int'(mode), 2);
    e     = mode_chg_cyc;
    found = 1'b0;
    ret   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mode == 2'd0) begin
        found = 1'b1;
        ret   = cyc;
        break;
      end
    end
    check("tmo_seen", int'(found), 1);
    check("tmo_delay", ret - e, 100);
    tick();
    h0 = hr_cnt;
    m0 = min_cnt;
    press(3'b010);
    check("run_up_ignored", (hr_cnt - h0) + (min_cnt - m0), 0);
    check("run_mode", int'(mode), 0);

    // Reset while repeating in SET_MIN.
    do_reset();
    press(3'b001);
    press(3'b001);
    m0        = min_cnt;
    keys_n[1] = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (min_cnt - m0 >= 3) begin
        found = 1'b1;
        break;
      end
    end
    check("rr_repeating", int'(found), 1);
    tick();
    rst = 1'b0;
    #1;
    check("rr_async_mode", int'(mode), 0);
    check("rr_async_outs", int'({set_hr, set_min, am2pm, blank_hr, blank_min}), 0);
    repeat (3) tick();
    rst = 1'b1;
    h0  = hr_cnt;
    m0  = min_cnt;
    repeat (40) tick();
    check("rr_no_inc", (hr_cnt - h0) + (min_cnt - m0), 0);
    check("rr_mode", int'(mode), 0);
    keys_n[1] = 1'b1;
    repeat (15) tick();

    check("invariants", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
